// File: rtl/axis_wr_arbiter_if.sv
// Write-port bundle between per-channel write engines and one AXI master.
// The master modport is the arbiter's view; slave is the surrounding system's.
interface axis_wr_arbiter_if #(
    parameter int CHANNELS       = 4,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 256
);
    logic [CHANNELS*AXI_ADDR_WIDTH-1:0] s_awaddr;
    logic [CHANNELS*AXI_LEN_WIDTH-1:0]  s_awlen;
    logic [CHANNELS-1:0]                s_awvalid;
    logic [CHANNELS-1:0]                s_awready;

    logic [CHANNELS*AXI_DATA_WIDTH-1:0] s_wdata;
    logic [CHANNELS-1:0]                s_wlast;
    logic [CHANNELS-1:0]                s_wvalid;
    logic [CHANNELS-1:0]                s_wready;

    logic [1:0]                         s_bresp;
    logic [CHANNELS-1:0]                s_bvalid;
    logic [CHANNELS-1:0]                s_bready;

    logic [AXI_ID_WIDTH-1:0]            m_awid;
    logic [AXI_ADDR_WIDTH-1:0]          m_awaddr;
    logic [AXI_LEN_WIDTH-1:0]           m_awlen;
    logic                               m_awvalid;
    logic                               m_awready;

    logic [AXI_DATA_WIDTH-1:0]          m_wdata;
    logic                               m_wlast;
    logic                               m_wvalid;
    logic                               m_wready;

    logic [AXI_ID_WIDTH-1:0]            m_bid;
    logic [1:0]                         m_bresp;
    logic                               m_bvalid;
    logic                               m_bready;

    modport master (
        input  s_awaddr,
        input  s_awlen,
        input  s_awvalid,
        output s_awready,
        input  s_wdata,
        input  s_wlast,
        input  s_wvalid,
        output s_wready,
        output s_bresp,
        output s_bvalid,
        input  s_bready,
        output m_awid,
        output m_awaddr,
        output m_awlen,
        output m_awvalid,
        input  m_awready,
        output m_wdata,
        output m_wlast,
        output m_wvalid,
        input  m_wready,
        input  m_bid,
        input  m_bresp,
        input  m_bvalid,
        output m_bready
    );

    modport slave (
        output s_awaddr,
        output s_awlen,
        output s_awvalid,
        input  s_awready,
        output s_wdata,
        output s_wlast,
        output s_wvalid,
        input  s_wready,
        input  s_bresp,
        input  s_bvalid,
        output s_bready,
        input  m_awid,
        input  m_awaddr,
        input  m_awlen,
        input  m_awvalid,
        output m_awready,
        input  m_wdata,
        input  m_wlast,
        input  m_wvalid,
        output m_wready,
        output m_bid,
        output m_bresp,
        output m_bvalid,
        input  m_bready
    );
endinterface

// File: rtl/axis_wr_arbiter.sv
// Round-robin AW arbiter merging several write channels onto one AXI port.
// W beats follow grant order through an order FIFO; B is routed by BID.
module axis_wr_arbiter #(
    parameter int CHANNELS       = 4,
    parameter int ORDER_AWIDTH   = 2,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 256
) (
    input logic               clk,
    input logic               rst,
    axis_wr_arbiter_if.master bus
);
    localparam int CW    = $clog2(CHANNELS);
    localparam int DEPTH = 1 << ORDER_AWIDTH;
    localparam int AW    = AXI_ADDR_WIDTH;
    localparam int LW    = AXI_LEN_WIDTH;
    localparam int DW    = AXI_DATA_WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]            state;
    logic [CW-1:0]         rr_ptr;
    logic [CW-1:0]         sel_q;
    logic [CW-1:0]         win_idx;
    logic                  win_found;
    logic                  grant;

    logic [AXI_ID_WIDTH-1:0] awid_q;
    logic [AW-1:0]           awaddr_q;
    logic [LW-1:0]           awlen_q;
    logic                    awvalid_q;

    logic [CW-1:0]           order_mem [DEPTH];
    logic [ORDER_AWIDTH:0]   wr_ptr;
    logic [ORDER_AWIDTH:0]   rd_ptr;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic [CW-1:0]           head;
    logic                    w_valid;

    // Channel index base+k, wrapping at CHANNELS (need not be a power of two).
    function automatic logic [CW-1:0] ch_at(input logic [CW-1:0] base,
                                            input int k);
        int j;
        j = int'(base) + k;
        if (j >= CHANNELS) j = j - CHANNELS;
        return CW'(j);
    endfunction

    // First requester at or after rr_ptr, searching upward with wrap.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!win_found && bus.s_awvalid[ch_at(rr_ptr, k)]) begin
                win_found = 1'b1;
                win_idx   = ch_at(rr_ptr, k);
            end
        end
    end

    assign grant = (state == ST_IDLE) && win_found && !fifo_full;

    // One-hot grant pulse, only in the cycle the request is taken in IDLE.
    always_comb begin
        bus.s_awready = '0;
        if (grant) bus.s_awready[win_idx] = 1'b1;
    end

    // AW state machine: latch winner in IDLE, hold it until m_awready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            sel_q     <= '0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awvalid_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state     <= ST_ISSUE;
                        sel_q     <= win_idx;
                        awid_q    <= AXI_ID_WIDTH'(win_idx);
                        awaddr_q  <= bus.s_awaddr[win_idx*AW +: AW];
                        awlen_q   <= bus.s_awlen[win_idx*LW +: LW];
                        awvalid_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.m_awready) begin
                        state     <= ST_IDLE;
                        awvalid_q <= 1'b0;
                        rr_ptr    <= ch_at(sel_q, 1);
                    end
                end
            endcase
        end
    end

    assign bus.m_awid    = awid_q;
    assign bus.m_awaddr  = awaddr_q;
    assign bus.m_awlen   = awlen_q;
    assign bus.m_awvalid = awvalid_q;

    // Order FIFO: the extra pointer bit tells full from empty.
    assign push       = (state == ST_ISSUE) && bus.m_awready;
    assign pop        = w_valid && bus.m_wready && bus.s_wlast[head];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ORDER_AWIDTH] != rd_ptr[ORDER_AWIDTH]) &&
        (wr_ptr[ORDER_AWIDTH-1:0] == rd_ptr[ORDER_AWIDTH-1:0]);
    assign head       = order_mem[rd_ptr[ORDER_AWIDTH-1:0]];

    // Storage needs no reset; emptiness is carried by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) order_mem[wr_ptr[ORDER_AWIDTH-1:0]] <= sel_q;
    end

    // FIFO pointers; a push and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign w_valid      = !fifo_empty && bus.s_wvalid[head];
    assign bus.m_wvalid = w_valid;
    assign bus.m_wdata  = bus.s_wdata[head*DW +: DW];
    assign bus.m_wlast  = bus.s_wlast[head];

    // Only the channel at the FIFO head may see m_wready.
    always_comb begin
        bus.s_wready = '0;
        if (!fifo_empty && bus.m_wready) bus.s_wready[head] = 1'b1;
    end

    // Route B back by BID; unknown IDs are acknowledged and dropped.
    always_comb begin
        bus.s_bvalid = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.s_bvalid[i] = bus.m_bvalid &&
                (bus.m_bid == AXI_ID_WIDTH'(i));
        end
    end

    assign bus.s_bresp  = bus.m_bresp;
    assign bus.m_bready =
        ({1'b0, bus.m_bid} < (AXI_ID_WIDTH+1)'(CHANNELS)) ?
        bus.s_bready[bus.m_bid[CW-1:0]] : 1'b1;

endmodule

// File: tb/tb_axis_wr_arbiter.sv
// Randomized bench for axis_wr_arbiter against a queue-based reference model.
// Grants, W ordering, B routing and async reset are checked every cycle.
module tb_axis_wr_arbiter;
    localparam int CH    = 4;
    localparam int OA    = 2;
    localparam int DEPTH = 1 << OA;
    localparam int IDW   = 8;
    localparam int LW    = 8;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    axis_wr_arbiter_if #(
        .CHANNELS(CH), .AXI_ID_WIDTH(IDW), .AXI_LEN_WIDTH(LW),
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)
    ) bus ();

    axis_wr_arbiter #(
        .CHANNELS(CH), .ORDER_AWIDTH(OA), .AXI_ID_WIDTH(IDW),
        .AXI_LEN_WIDTH(LW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // channel-side stimulus state
    bit            req [CH];
    logic [AW-1:0] req_addr [CH];
    logic [LW-1:0] req_len [CH];
    bit            wv [CH];
    beat_t         chq [CH][$];
    bit            w_en;
    int            aw_hold;

    // reference model
    int            rr;
    bit            aw_pend;
    int            pend_ch;
    logic [AW-1:0] pend_addr;
    logic [LW-1:0] pend_len;
    beat_t         pend_beats[$];
    int            order_q[$];
    beat_t         exp_w[$];

    // events sampled at negedge, applied at the following posedge
    bit ev_grant;
    int ev_win;
    bit ev_aw_hs;
    bit ev_w_hs;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.s_awaddr  = '0;
        bus.s_awlen   = '0;
        bus.s_awvalid = '0;
        bus.s_wdata   = '0;
        bus.s_wlast   = '0;
        bus.s_wvalid  = '0;
        bus.s_bready  = '0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bid     = '0;
        bus.m_bresp   = '0;
        bus.m_bvalid  = 1'b0;
    endtask

    task automatic model_reset();
        rr      = 0;
        aw_pend = 0;
        pend_beats.delete();
        order_q.delete();
        exp_w.delete();
        for (int c = 0; c < CH; c++) begin
            req[c] = 0;
            wv[c]  = 0;
            chq[c].delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        chk("rst_awvalid", bus.m_awvalid, 0);
        chk("rst_awaddr", bus.m_awaddr, 0);
        chk("rst_awlen", bus.m_awlen, 0);
        chk("rst_awid", bus.m_awid, 0);
        chk("rst_awready", bus.s_awready, 0);
        chk("rst_wvalid", bus.m_wvalid, 0);
        chk("rst_wready", bus.s_wready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input bit new_ok);
        for (int c = 0; c < CH; c++) begin
            if (new_ok && !req[c] && $urandom_range(0, 2) == 0) begin
                req[c]      = 1;
                req_addr[c] = $urandom;
                req_len[c]  = LW'($urandom_range(0, 5));
            end
            wv[c] = w_en && chq[c].size() > 0 && $urandom_range(0, 3) != 0;
            bus.s_awvalid[c]         = req[c];
            bus.s_awaddr[c*AW +: AW] = req_addr[c];
            bus.s_awlen[c*LW +: LW]  = req_len[c];
            if (chq[c].size() > 0) begin
                bus.s_wdata[c*DW +: DW] = chq[c][0].d;
                bus.s_wlast[c]          = chq[c][0].l;
            end else begin
                bus.s_wdata[c*DW +: DW] = '0;
                bus.s_wlast[c]          = 1'b0;
            end
            bus.s_wvalid[c] = wv[c];
        end
        if (aw_hold > 0) begin
            bus.m_awready = 1'b0;
            aw_hold--;
        end else begin
            bus.m_awready = ($urandom_range(0, 3) != 0);
        end
        bus.m_wready = ($urandom_range(0, 2) != 0);
        bus.m_bvalid = 1'($urandom_range(0, 1));
        bus.m_bid    = IDW'($urandom_range(0, 5));
        bus.m_bresp  = 2'($urandom);
        bus.s_bready = CH'($urandom);
    endtask

    task automatic check_cycle();
        logic [CH-1:0] eg;
        logic [CH-1:0] ewr;
        logic [CH-1:0] ebv;
        bit            ewv;
        bit            ebr;
        int            hd;
        int            j;
        eg       = '0;
        ev_grant = 0;
        ev_win   = 0;
        if (!aw_pend && order_q.size() < DEPTH) begin
            for (int k = 0; k < CH; k++) begin
                j = (rr + k) % CH;
                if (!ev_grant && req[j]) begin
                    ev_grant = 1;
                    ev_win   = j;
                end
            end
        end
        if (ev_grant) eg[ev_win] = 1'b1;
        chk("s_awready", bus.s_awready, eg);
        chk("m_awvalid", bus.m_awvalid, aw_pend);
        if (aw_pend) begin
            chk("m_awid", bus.m_awid, pend_ch);
            chk("m_awaddr", bus.m_awaddr, pend_addr);
            chk("m_awlen", bus.m_awlen, pend_len);
        end
        ev_aw_hs = aw_pend && bus.m_awready;

        hd  = (order_q.size() > 0) ? order_q[0] : 0;
        ewv = order_q.size() > 0 && wv[hd];
        ewr = '0;
        if (order_q.size() > 0 && bus.m_wready) ewr[hd] = 1'b1;
        chk("m_wvalid", bus.m_wvalid, ewv);
        chk("s_wready", bus.s_wready, ewr);
        if (ewv) begin
            chk("m_wdata", bus.m_wdata, exp_w[0].d);
            chk("m_wlast", bus.m_wlast, exp_w[0].l);
        end
        ev_w_hs = ewv && bus.m_wready;

        for (int i = 0; i < CH; i++)
            ebv[i] = bus.m_bvalid && (int'(bus.m_bid) == i);
        ebr = (int'(bus.m_bid) < CH) ? bus.s_bready[int'(bus.m_bid)] : 1'b1;
        chk("s_bvalid", bus.s_bvalid, ebv);
        chk("s_bresp", bus.s_bresp, bus.m_bresp);
        chk("m_bready", bus.m_bready, ebr);
    endtask

    task automatic apply_events();
        beat_t b;
        int    hd;
        if (ev_aw_hs) begin
            order_q.push_back(pend_ch);
            foreach (pend_beats[i]) exp_w.push_back(pend_beats[i]);
            pend_beats.delete();
            rr      = (pend_ch + 1) % CH;
            aw_pend = 0;
        end
        if (ev_w_hs) begin
            hd = order_q[0];
            b  = exp_w.pop_front();
            void'(chq[hd].pop_front());
            if (b.l) void'(order_q.pop_front());
        end
        if (ev_grant) begin
            aw_pend   = 1;
            pend_ch   = ev_win;
            pend_addr = req_addr[ev_win];
            pend_len  = req_len[ev_win];
            for (int i = 0; i <= int'(req_len[ev_win]); i++) begin
                b.d = $urandom;
                b.l = (i == int'(req_len[ev_win]));
                chq[ev_win].push_back(b);
                pend_beats.push_back(b);
            end
            req[ev_win] = 0;
        end
    endtask

    task automatic step(input bit new_ok, input bit rr_chk);
        drive(new_ok);
        @(negedge clk);
        check_cycle();
        if (rr_chk) chk("rr_after_rst", bus.s_awready, 1);
        @(posedge clk);
        apply_events();
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        w_en    = 1;
        aw_hold = 0;
        clear_inputs();
        model_reset();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            w_en = !(cyc >= 800 && cyc < 860);
            if (cyc == 1500) aw_hold = 12;
            if (cyc == 2200) begin
                do_reset();
                req[0]      = 1;
                req_addr[0] = 32'h1000;
                req_len[0]  = 8'd3;
                req[3]      = 1;
                req_addr[3] = 32'h3000;
                req_len[3]  = 8'd1;
                step(0, 1);
            end else begin
                step(1, 0);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
